// File: rtl/sha256_block_packer.sv
// sha256_block_packer: packs a byte stream into 512-bit blocks for the sha256 core.
//
// Bytes are placed MSB-first: byte 0 of a block lands in block_o[511:504]. The
// packer owns all message framing. It clears the core at the start of every
// message, sends full blocks with end_o=0, and sends the final (possibly partial)
// block with end_o=1 and last_o set to the number of valid bits. If a message
// ends exactly on a block boundary via flush_i, it sends an end-only beat
// (valid_o=0, end_o=1, last_o=0).
//
// Ports:
//   clk, reset       clock; synchronous active-high reset
//   byte_i/byte_valid_i/byte_last_i/byte_ready_o   byte stream in (valid/ready)
//   flush_i/flush_ready_o                          end message without a byte
//   clear_o, block_o, valid_o, end_o, last_o        core block interface
//   ready_i                                         core ready
//   busy_o                                          message in progress
//
// Optional feature (macro SHA256_PACKER_BYTECNT_EN): adds msg_bytes_o, a
// saturating count of bytes accepted for the current message.

module sha256_block_packer #(
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned CLEAR_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       byte_i,
    input  logic             byte_valid_i,
    input  logic             byte_last_i,
    output logic             byte_ready_o,
    input  logic             flush_i,
    output logic             flush_ready_o,
    output logic             clear_o,
    output logic [511:0]     block_o,
    output logic             valid_o,
    output logic             end_o,
    output logic [9:0]       last_o,
    input  logic             ready_i,
`ifdef SHA256_PACKER_BYTECNT_EN
    output logic [CNT_W-1:0] msg_bytes_o,
`endif
    output logic             busy_o
);

    localparam logic [1:0] ClrLast = 2'(CLEAR_CYCLES - 1);

    typedef enum logic [1:0] {StClr, StFill, StSend} state_e;

    state_e         state_q, state_d;
    logic [5:0]     idx_q, idx_d;
    logic           started_q, started_d;
    logic [1:0]     clr_cnt_q, clr_cnt_d;
    logic [511:0]   block_q, block_d;
    logic           valid_q, valid_d;
    logic           end_q, end_d;
    logic [9:0]     last_q, last_d;
    logic [9:0]     fill_bytes;

    // A flush arriving with a byte turns that byte into the final one.
    logic is_final;
    assign is_final   = byte_last_i | flush_i;
    assign fill_bytes = {4'b0000, idx_q} + 10'd1;

`ifdef SHA256_PACKER_BYTECNT_EN
    logic [CNT_W-1:0] msg_bytes_q, msg_bytes_d;
`endif

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StClr;
            idx_q     <= '0;
            started_q <= 1'b0;
            clr_cnt_q <= '0;
            block_q   <= '0;
            valid_q   <= 1'b0;
            end_q     <= 1'b0;
            last_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            started_q <= started_d;
            clr_cnt_q <= clr_cnt_d;
            block_q   <= block_d;
            valid_q   <= valid_d;
            end_q     <= end_d;
            last_q    <= last_d;
        end
    end

`ifdef SHA256_PACKER_BYTECNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            msg_bytes_q <= '0;
        end else begin
            msg_bytes_q <= msg_bytes_d;
        end
    end

    always_comb begin
        msg_bytes_d = msg_bytes_q;
        if (state_q == StClr) begin
            msg_bytes_d = '0;
        end else if (state_q == StFill && byte_valid_i && msg_bytes_q != '1) begin
            msg_bytes_d = msg_bytes_q + CNT_W'(1);
        end
    end

    assign msg_bytes_o = msg_bytes_q;
`endif

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StClr: begin
                if (clr_cnt_q == ClrLast) state_d = StFill;
            end
            StFill: begin
                if (byte_valid_i) begin
                    if (is_final || idx_q == 6'd63) state_d = StSend;
                end else if (flush_i) begin
                    state_d = StSend;
                end
            end
            StSend: begin
                if (ready_i) state_d = end_q ? StClr : StFill;
            end
            default: state_d = StClr;
        endcase
    end

    // Datapath next values.
    always_comb begin
        idx_d     = idx_q;
        started_d = started_q;
        clr_cnt_d = clr_cnt_q;
        block_d   = block_q;
        valid_d   = valid_q;
        end_d     = end_q;
        last_d    = last_q;
        unique case (state_q)
            StClr: begin
                clr_cnt_d = (clr_cnt_q == ClrLast) ? 2'd0 : clr_cnt_q + 2'd1;
            end
            StFill: begin
                if (byte_valid_i) begin
                    // Lane idx starts at bit 511-8*idx, i.e. base 8*(63-idx).
                    block_d[{~idx_q, 3'b000} +: 8] = byte_i;
                    idx_d     = idx_q + 6'd1;
                    started_d = 1'b1;
                    if (is_final) begin
                        valid_d = 1'b1;
                        end_d   = 1'b1;
                        last_d  = {fill_bytes[6:0], 3'b000};
                    end else if (idx_q == 6'd63) begin
                        valid_d = 1'b1;
                        end_d   = 1'b0;
                        last_d  = '0;
                    end
                end else if (flush_i) begin
                    // Nothing buffered: end-only beat.
                    valid_d = (idx_q != 6'd0);
                    end_d   = 1'b1;
                    last_d  = {1'b0, idx_q, 3'b000};
                end
            end
            StSend: begin
                if (ready_i) begin
                    block_d = '0;
                    idx_d   = '0;
                    valid_d = 1'b0;
                    end_d   = 1'b0;
                    last_d  = '0;
                    if (end_q) started_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Outputs; handshake strobes are held low while reset is asserted.
    always_comb begin
        clear_o       = !reset && (state_q == StClr);
        byte_ready_o  = !reset && (state_q == StFill);
        flush_ready_o = !reset && (state_q == StFill);
        busy_o        = !reset && ((state_q == StClr) || (state_q == StSend) ||
                                   ((state_q == StFill) && started_q));
        block_o       = block_q;
        valid_o       = valid_q;
        end_o         = end_q;
        last_o        = last_q;
    end

endmodule

// File: tb/tb_sha256_block_packer.sv
// Scoreboard bench for sha256_block_packer. Whole messages are turned into
// expected block beats by a byte-level reference model when issued. A monitor
// pops and compares on every core-side transfer.
module tb_sha256_block_packer;

    localparam int unsigned ClearCycles = 2;
    localparam int unsigned CntW        = 32;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [7:0]     byte_i = '0;
    logic           byte_valid_i = 1'b0;
    logic           byte_last_i = 1'b0;
    logic           byte_ready_o;
    logic           flush_i = 1'b0;
    logic           flush_ready_o;
    logic           clear_o;
    logic [511:0]   block_o;
    logic           valid_o;
    logic           end_o;
    logic [9:0]     last_o;
    logic           ready_i = 1'b0;
    logic           busy_o;
`ifdef SHA256_PACKER_BYTECNT_EN
    logic [CntW-1:0] msg_bytes_o;
`endif

    sha256_block_packer #(
        .CNT_W        (CntW),
        .CLEAR_CYCLES (ClearCycles)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .byte_i        (byte_i),
        .byte_valid_i  (byte_valid_i),
        .byte_last_i   (byte_last_i),
        .byte_ready_o  (byte_ready_o),
        .flush_i       (flush_i),
        .flush_ready_o (flush_ready_o),
        .clear_o       (clear_o),
        .block_o       (block_o),
        .valid_o       (valid_o),
        .end_o         (end_o),
        .last_o        (last_o),
        .ready_i       (ready_i),
`ifdef SHA256_PACKER_BYTECNT_EN
        .msg_bytes_o   (msg_bytes_o),
`endif
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [511:0] blk;
        logic         vld;
        logic         en;
        logic [9:0]   last;
        int unsigned  nbytes;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  msg_q[$];
    int          errors = 0;
    int          checks = 0;
    bit          hold_ready = 1'b0;
    bit          mon_hold = 1'b0;
    logic [511:0] held_blk;
    logic [9:0]  held_last;
    logic        held_end;
    logic        held_vld;
    int          clr_seen = 0;
    exp_t        mon_e;

    task automatic chk(input bit ok, input string name, input logic [511:0] act,
                       input logic [511:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Reference model: one beat per 64-byte chunk; the final chunk carries end.
    task automatic add_block(input int pos, input int len, input bit fin);
        exp_t e;
        e.blk = '0;
        for (int i = 0; i < len; i++) e.blk[511-8*i -: 8] = msg_q[pos+i];
        e.vld    = 1'b1;
        e.en     = fin;
        e.last   = fin ? 10'(8 * len) : 10'd0;
        e.nbytes = pos + len;
        exp_q.push_back(e);
    endtask

    // mode 0: last flag on final byte; 1: flush after bytes; 2: flush with final byte
    task automatic model(input int n, input int mode);
        exp_t e;
        int pos = 0;
        while ((mode == 1) ? (n - pos >= 64) : (n - pos > 64)) begin
            add_block(pos, 64, 1'b0);
            pos += 64;
        end
        if (n - pos == 0) begin
            e.blk = '0; e.vld = 1'b0; e.en = 1'b1; e.last = '0; e.nbytes = n;
            exp_q.push_back(e);
        end else begin
            add_block(pos, n - pos, 1'b1);
        end
    endtask

    task automatic idle_gap();
        int n = $urandom_range(0, 2);
        byte_valid_i = 1'b0; byte_last_i = 1'b0; flush_i = 1'b0;
        byte_i = 8'($urandom);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic push_byte(input logic [7:0] b, input bit lst, input bit fl);
        bit done = 1'b0;
        int t = 0;
        idle_gap();
        byte_i = b; byte_valid_i = 1'b1; byte_last_i = lst; flush_i = fl;
        while (!done) begin
            @(negedge clk);
            done = byte_ready_o;
            @(posedge clk); #1;
            t++;
            if (!done && t > 3000) begin
                chk(1'b0, "byte_accept_timeout", 0, 1);
                done = 1'b1;
            end
        end
        byte_valid_i = 1'b0; byte_last_i = 1'b0; flush_i = 1'b0;
    endtask

    task automatic do_flush();
        bit done = 1'b0;
        int t = 0;
        idle_gap();
        flush_i = 1'b1;
        while (!done) begin
            @(negedge clk);
            done = flush_ready_o;
            @(posedge clk); #1;
            t++;
            if (!done && t > 3000) begin
                chk(1'b0, "flush_accept_timeout", 0, 1);
                done = 1'b1;
            end
        end
        flush_i = 1'b0;
    endtask

    task automatic send_msg(input int mode);
        int n = msg_q.size();
        model(n, mode);
        for (int i = 0; i < n; i++)
            push_byte(msg_q[i], (mode == 0) && (i == n - 1), (mode == 2) && (i == n - 1));
        if (mode == 1) do_flush();
    endtask

    task automatic set_str(input string s);
        msg_q.delete();
        for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
    endtask

    task automatic fill_const(input int n, input logic [7:0] b);
        msg_q.delete();
        for (int i = 0; i < n; i++) msg_q.push_back(b);
    endtask

    task automatic fill_rand(input int n);
        msg_q.delete();
        for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 5000) begin @(posedge clk); #1; t++; end
        chk(exp_q.size() == 0, "drain", exp_q.size(), 0);
    endtask

    // Core-side ready: random unless held off.
    initial begin
        forever begin
            @(posedge clk); #1;
            ready_i = hold_ready ? 1'b0 : ($urandom_range(0, 2) != 0);
        end
    end

    // Monitor: a transfer happens at the next rising edge when a beat is
    // presented and ready_i is high.
    always @(negedge clk) begin
        if (reset) begin
            clr_seen = 0;
            mon_hold = 1'b0;
        end else begin
            if (clear_o) clr_seen++;
            if (valid_o || end_o) begin
                chk(!byte_ready_o && !flush_ready_o && busy_o, "send_handshake",
                    {509'b0, byte_ready_o, flush_ready_o, busy_o}, 512'b1);
                if (mon_hold)
                    chk(block_o == held_blk && last_o == held_last && end_o == held_end &&
                        valid_o == held_vld, "send_stable", block_o, held_blk);
                if (ready_i) begin
                    mon_hold = 1'b0;
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_beat", block_o, 0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk(block_o == mon_e.blk, "block", block_o, mon_e.blk);
                        chk(valid_o == mon_e.vld, "valid", valid_o, mon_e.vld);
                        chk(end_o == mon_e.en, "end", end_o, mon_e.en);
                        chk(last_o == mon_e.last, "last", last_o, mon_e.last);
`ifdef SHA256_PACKER_BYTECNT_EN
                        chk(msg_bytes_o == mon_e.nbytes, "msg_bytes", msg_bytes_o,
                            mon_e.nbytes);
`endif
                        if (mon_e.en) begin
                            chk(clr_seen == ClearCycles, "clear_len", clr_seen, ClearCycles);
                            clr_seen = 0;
                        end
                    end
                end else begin
                    mon_hold  = 1'b1;
                    held_blk  = block_o;
                    held_last = last_o;
                    held_end  = end_o;
                    held_vld  = valid_o;
                end
            end else begin
                mon_hold = 1'b0;
            end
        end
    end

    initial begin
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int m;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(clear_o == 1'b0, "rst_clear", clear_o, 0);
        chk(valid_o == 1'b0, "rst_valid", valid_o, 0);
        chk(end_o == 1'b0, "rst_end", end_o, 0);
        chk(last_o == 10'd0, "rst_last", last_o, 0);
        chk(block_o == '0, "rst_block", block_o, 0);
        chk(byte_ready_o == 1'b0, "rst_byte_ready", byte_ready_o, 0);
        chk(flush_ready_o == 1'b0, "rst_flush_ready", flush_ready_o, 0);
        chk(busy_o == 1'b0, "rst_busy", busy_o, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        set_str("abc"); send_msg(0);
        set_str("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq"); send_msg(0);
        fill_const(64, 8'h61); send_msg(1);
        fill_const(64, 8'h61); send_msg(0);
        msg_q.delete(); send_msg(1);
        wait_drain();

        // Backpressure: the beat must sit still and no byte may be taken.
        hold_ready = 1'b1;
        fill_rand(30); send_msg(0);
        byte_valid_i = 1'b1; byte_i = 8'hA5;
        repeat (20) begin @(posedge clk); #1; end
        byte_valid_i = 1'b0;
        @(negedge clk);
        chk(valid_o && end_o && exp_q.size() == 1, "bp_held",
            {valid_o, end_o, 10'(exp_q.size())}, {1'b1, 1'b1, 10'd1});
        @(posedge clk); #1;
        hold_ready = 1'b0;

        fill_rand(63);  send_msg(2);
        fill_rand(65);  send_msg(1);
        fill_rand(128); send_msg(1);
        fill_rand(1);   send_msg(2);
        for (int k = 0; k < 16; k++) begin
            n = $urandom_range(0, 200);
            m = (n == 0) ? 1 : $urandom_range(0, 2);
            fill_rand(n);
            send_msg(m);
        end
        wait_drain();

        // Reset mid-message: the partial bytes must never surface.
        fill_rand(10);
        for (int i = 0; i < 10; i++) push_byte(msg_q[i], 1'b0, 1'b0);
        reset = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
        set_str("abc"); send_msg(0);
        wait_drain();

        repeat (ClearCycles + 3) begin @(posedge clk); #1; end
        @(negedge clk);
        chk(!busy_o && byte_ready_o && !clear_o, "idle_fill",
            {busy_o, byte_ready_o, clear_o}, 3'b010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sha256_block_packer.md
Name: sha256_block_packer

Overview:
Front-end feeder for the sha256 core. Accepts a byte stream with a per-byte last flag and packs it MSB-first into 512-bit blocks. Drives the core's block interface: clear, block/valid, end, last-bit-count; obeys the core's ready. Sits between the DMA/byte source and the sha256 instance; owns all message framing so the core never sees partial-block bookkeeping.

Parameters:
CNT_W, 32, width of message byte counter (saturating), used by optional feature.
CLEAR_CYCLES, 1, number of cycles clear_o is held high at message start (1..4).

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
byte_i  in  8  message byte
byte_valid_i  in  1  byte_i valid
byte_last_i  in  1  byte_i is final byte of message
byte_ready_o  out  1  packer accepts byte this cycle
flush_i  in  1  end message with no further byte (empty message, or end after last accepted byte without byte_last_i)
flush_ready_o  out  1  flush_i accepted this cycle (FILL state only)
clear_o  out  1  to core clear_i
block_o  out  512  to core block_i; byte 0 in bits [511:504]
valid_o  out  1  to core valid_i
end_o  out  1  to core end_i
last_o  out  10  to core last_i; valid bits in final block (0..512)
ready_i  in  1  from core ready_o
busy_o  out  1  message in progress (CLR, FILL with bytes/blocks pending, SEND)

Behaviour:
- Reset: state CLR, clear_o=0, valid_o=0, end_o=0, last_o=0, block_o=0, byte_ready_o=0, flush_ready_o=0, busy_o=0, byte index=0, started flag=0.
- States: CLR, FILL, SEND.
- CLR: clear_o=1 for CLEAR_CYCLES consecutive cycles, byte_ready_o=0; then FILL. Entered after reset and after every end transfer.
- FILL: byte_ready_o=1, flush_ready_o=1. Byte transfer = byte_valid_i && byte_ready_o; byte written to lane idx (bits [511-8*idx -: 8]), idx++, started=1.
  - Byte with idx==63 and !byte_last_i: -> SEND, end_o=0, last_o=0.
  - Byte with byte_last_i (any idx): -> SEND, end_o=1, last_o=8*(idx+1) (idx 63 -> 512).
  - flush_i with no byte: if idx>0 -> SEND, end_o=1, last_o=8*idx; if idx==0 -> SEND end-only (valid_o=0, end_o=1, last_o=0; covers empty message and exact-multiple-of-64 messages).
  - byte and flush same cycle: byte taken first, treated as byte_last_i=1; flush consumed.
- SEND: byte_ready_o=0, flush_ready_o=0. valid_o=1 (except end-only). Outputs stable until transfer = ready_i high at rising edge. On transfer: valid_o/end_o drop next cycle, idx=0, unused lanes of block_o zeroed; if end_o was 1 -> CLR, started=0; else -> FILL.
- Unused byte lanes of a final block are 0; core handles padding.
- ready_i low indefinitely: packer holds in SEND, no bytes lost (backpressure via byte_ready_o).
- Reset mid-message: all state discarded next cycle; returns to CLR, so core is cleared before next message.
- Latency: last byte accepted at cycle N -> valid_o high at N+1; byte_ready_o re-asserts cycle after non-final transfer.
- Throughput: 64 byte cycles + 1 send cycle (ready_i high) per block.

Optional Feature:
SHA256_PACKER_BYTECNT_EN: adds output msg_bytes_o [CNT_W-1:0]: counts accepted bytes of current message, saturates at all-ones, cleared in CLR, holds final value until next CLR. Without macro: port absent, no counter logic.

Test Plan:
- Empty: reset, flush_i pulse in FILL -> one clear_o pulse earlier, then end_o=1, valid_o=0, last_o=0; core digest e3b0c442...7852b855.
- "abc": bytes 61,62,63 (last on 63) -> block_o={32'h61626300,480'b0}, valid_o=1, end_o=1, last_o=24; digest ba7816bf...f20015ad.
- 56-byte "abcdbcde...nopq" with last -> single final block, last_o=448; digest 248d6a61...19db06c1.
- 64 bytes 0x61 no last, then flush -> full block end_o=0, then end-only last_o=0; 64 bytes with last on 64th -> one block end_o=1, last_o=512.
- Backpressure: hold ready_i=0 20 cycles in SEND -> block_o stable, byte_ready_o=0, no byte accepted; release -> transfer, resume.
- 1M 'a' random byte_valid_i gaps, random ready_i -> 15625 blocks, final last_o=512; digest cdc76e5c...c7112cd0; msg_bytes_o=1000000 with SHA256_PACKER_BYTECNT_EN.
